// File: rtl/iob_clint_rtc.sv
// -----------------------------------------------------------------------------
// iob_clint_rtc
// RISC-V style core-local interruptor (CLINT) with a prescaled 64-bit real-time
// counter, reached through a simple valid/ready register bus.
//
// Ports
//   clk      : single clock, all state updates on its rising edge
//   reset    : asynchronous active-high reset, clears all state immediately
//   valid    : request strobe, held by the master until ready
//   address  : byte address, bits [15:2] decoded, [1:0] ignored
//   wdata    : write data
//   wstrb    : byte write enables, all-zero means read
//   rdata    : read data, meaningful only while ready=1
//   ready    : one-cycle completion pulse, one cycle after the request
//   mtip     : per-hart machine timer interrupt (registered)
//   msip     : per-hart machine software interrupt (registered)
//
// Register map (word aligned, k = hart index)
//   0x0000+4k  MSIP[k]          bit0
//   0x4000+8k  MTIMECMP[k] low  0x4004+8k high
//   0xBFF0     CTRL             bit0 = EN
//   0xBFF4     PRESC            bits [PRESC_W-1:0]
//   0xBFF8     MTIME low        0xBFFC high (high reads return the shadow)
// -----------------------------------------------------------------------------
module iob_clint_rtc #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int N_CORES = 1,
    parameter int PRESC_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic [N_CORES-1:0]  mtip,
    output logic [N_CORES-1:0]  msip
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    // Replace only the byte lanes selected by strb.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic [0:0]         state_r;
    logic [63:0]        mtime_r;
    logic [31:0]        shadow_r;
    logic [PRESC_W-1:0] pcnt_r;
    logic [PRESC_W-1:0] presc_r;
    logic               en_r;
    logic [63:0]        mtimecmp_r [N_CORES];
    logic [N_CORES-1:0] msip_reg_r;

    logic [13:0]        word_s;
    logic               unused_addr_s;
    logic               req_s;
    logic               wr_s;
    logic               rd_s;
    logic               sel_msip_s;
    logic               sel_cmp_s;
    logic               sel_ctrl_s;
    logic               sel_presc_s;
    logic               sel_mtl_s;
    logic               sel_mth_s;
    logic [2:0]         msip_hart_s;
    logic [2:0]         cmp_hart_s;
    logic               cmp_hi_s;
    logic               tick_s;
    logic [PRESC_W-1:0] pcnt_nx_s;
    logic [63:0]        mtime_nx_s;
    logic [31:0]        rd_data_s;
    logic [31:0]        presc_merged_s;

    assign word_s        = address[15:2];
    assign unused_addr_s = ^address[1:0];

    assign req_s = (state_r == ST_IDLE) && valid;
    assign wr_s  = req_s && (|wstrb);
    assign rd_s  = req_s && !(|wstrb);

    assign sel_msip_s  = (word_s[13:3] == 11'd0);
    assign sel_cmp_s   = (word_s[13:4] == 10'h100);
    assign sel_ctrl_s  = (word_s == 14'h2FFC);
    assign sel_presc_s = (word_s == 14'h2FFD);
    assign sel_mtl_s   = (word_s == 14'h2FFE);
    assign sel_mth_s   = (word_s == 14'h2FFF);
    assign msip_hart_s = word_s[2:0];
    assign cmp_hart_s  = word_s[3:1];
    assign cmp_hi_s    = word_s[0];

    assign tick_s         = en_r && (pcnt_r == presc_r);
    assign presc_merged_s = merge_bytes(32'(presc_r), wdata, wstrb);

    // Read mux; harts beyond N_CORES never match the loop and read 0.
    always_comb begin
        rd_data_s = 32'd0;
        if (sel_msip_s) begin
            for (int i = 0; i < N_CORES; i++) begin
                rd_data_s = rd_data_s |
                    ((msip_hart_s == 3'(i)) ? {31'd0, msip_reg_r[i]} : 32'd0);
            end
        end else if (sel_cmp_s) begin
            for (int i = 0; i < N_CORES; i++) begin
                rd_data_s = rd_data_s |
                    ((cmp_hart_s == 3'(i)) ?
                        (cmp_hi_s ? mtimecmp_r[i][63:32] : mtimecmp_r[i][31:0]) :
                        32'd0);
            end
        end else if (sel_ctrl_s) begin
            rd_data_s = {31'd0, en_r};
        end else if (sel_presc_s) begin
            rd_data_s = 32'(presc_r);
        end else if (sel_mtl_s) begin
            rd_data_s = mtime_r[31:0];
        end else if (sel_mth_s) begin
            rd_data_s = shadow_r;
        end else begin
            rd_data_s = 32'd0;
        end
    end

    // Prescaler next state: a PRESC write restarts the count.
    always_comb begin
        pcnt_nx_s = pcnt_r;
        if (wr_s && sel_presc_s) begin
            pcnt_nx_s = {PRESC_W{1'b0}};
        end else if (tick_s) begin
            pcnt_nx_s = {PRESC_W{1'b0}};
        end else if (en_r) begin
            pcnt_nx_s = pcnt_r + PRESC_W'(1'b1);
        end else begin
            pcnt_nx_s = pcnt_r;
        end
    end

    // mtime next state: a bus write to either half overrides that cycle's
    // increment entirely, so no carry crosses into the other half.
    always_comb begin
        mtime_nx_s = mtime_r;
        if (wr_s && sel_mtl_s) begin
            mtime_nx_s = {mtime_r[63:32], merge_bytes(mtime_r[31:0], wdata, wstrb)};
        end else if (wr_s && sel_mth_s) begin
            mtime_nx_s = {merge_bytes(mtime_r[63:32], wdata, wstrb), mtime_r[31:0]};
        end else if (tick_s) begin
            mtime_nx_s = mtime_r + 64'd1;
        end else begin
            mtime_nx_s = mtime_r;
        end
    end

    // Bus handshake: accept in IDLE, answer with a one-cycle ready in RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            ready   <= 1'b0;
            rdata   <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (valid) begin
                        state_r <= ST_RESP;
                        ready   <= 1'b1;
                        rdata   <= (|wstrb) ? 32'd0 : rd_data_s;
                    end else begin
                        ready   <= 1'b0;
                        rdata   <= 32'd0;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    ready   <= 1'b0;
                    rdata   <= 32'd0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready   <= 1'b0;
                    rdata   <= 32'd0;
                end
            endcase
        end
    end

    // Time base and the high-word shadow captured by MTIME low reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt_r   <= {PRESC_W{1'b0}};
            mtime_r  <= 64'd0;
            shadow_r <= 32'd0;
        end else begin
            pcnt_r  <= pcnt_nx_s;
            mtime_r <= mtime_nx_s;
            if (rd_s && sel_mtl_s) begin
                shadow_r <= mtime_r[63:32];
            end
        end
    end

    // Software-visible configuration registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_r       <= 1'b1;
            presc_r    <= {PRESC_W{1'b0}};
            msip_reg_r <= {N_CORES{1'b0}};
            for (int i = 0; i < N_CORES; i++) begin
                mtimecmp_r[i] <= {64{1'b1}};
            end
        end else begin
            if (wr_s && sel_ctrl_s && wstrb[0]) begin
                en_r <= wdata[0];
            end
            if (wr_s && sel_presc_s) begin
                presc_r <= PRESC_W'(presc_merged_s);
            end
            for (int i = 0; i < N_CORES; i++) begin
                if (wr_s && sel_msip_s && (msip_hart_s == 3'(i)) && wstrb[0]) begin
                    msip_reg_r[i] <= wdata[0];
                end
                if (wr_s && sel_cmp_s && (cmp_hart_s == 3'(i))) begin
                    if (cmp_hi_s) begin
                        mtimecmp_r[i][63:32] <= merge_bytes(mtimecmp_r[i][63:32], wdata, wstrb);
                    end else begin
                        mtimecmp_r[i][31:0] <= merge_bytes(mtimecmp_r[i][31:0], wdata, wstrb);
                    end
                end
            end
        end
    end

    // Registered interrupt outputs, one cycle behind their sources.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtip <= {N_CORES{1'b0}};
            msip <= {N_CORES{1'b0}};
        end else begin
            for (int i = 0; i < N_CORES; i++) begin
                mtip[i] <= (mtime_r >= mtimecmp_r[i]);
            end
            msip <= msip_reg_r;
        end
    end

endmodule

// File: tb/tb_iob_clint_rtc.sv
// -----------------------------------------------------------------------------
// tb_iob_clint_rtc
// Directed, self-checking bench for iob_clint_rtc (N_CORES=2, PRESC_W=16):
// a register-access vector table followed by hand-written timing sequences.
// -----------------------------------------------------------------------------
module tb_iob_clint_rtc;

    logic        clk;
    logic        reset;
    logic        valid;
    logic [15:0] address;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;
    logic [1:0]  mtip;
    logic [1:0]  msip;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int base    = 0;

    typedef struct {
        logic        is_wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    iob_clint_rtc #(
        .ADDR_W (16),
        .DATA_W (32),
        .N_CORES(2),
        .PRESC_W(16)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .valid  (valid),
        .address(address),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .rdata  (rdata),
        .ready  (ready),
        .mtip   (mtip),
        .msip   (msip)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        valid   = 1'b0;
        wstrb   = 4'h0;
        address = 16'h0000;
        wdata   = 32'h0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        base  = cyc;
    endtask

    // One bus transaction: request, check ready pulse, check ready drop.
    task automatic xact(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                        input string name, output logic [31:0] r);
        address = a;
        wdata   = d;
        wstrb   = s;
        valid   = 1'b1;
        @(posedge clk);
        #1;
        check({name, " ready"}, 64'(ready), 64'd1);
        r     = rdata;
        valid = 1'b0;
        wstrb = 4'h0;
        @(posedge clk);
        #1;
        check({name, " ready drop"}, 64'(ready), 64'd0);
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        xact(a, d, s, $sformatf("wr %h", a), dummy);
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] r);
        xact(a, 32'h0, 4'h0, $sformatf("rd %h", a), r);
    endtask

    initial begin
        logic [31:0] r, m1, m2, m3;

        vecs[0]  = '{1'b0, 16'h0000, 32'h0,        4'h0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 16'h4000, 32'h0,        4'h0, 32'hFFFF_FFFF};
        vecs[2]  = '{1'b0, 16'h400C, 32'h0,        4'h0, 32'hFFFF_FFFF};
        vecs[3]  = '{1'b0, 16'hBFF0, 32'h0,        4'h0, 32'h0000_0001};
        vecs[4]  = '{1'b0, 16'hBFF4, 32'h0,        4'h0, 32'h0000_0000};
        vecs[5]  = '{1'b1, 16'h4008, 32'h1234_5678, 4'h5, 32'h0};
        vecs[6]  = '{1'b0, 16'h4008, 32'h0,        4'h0, 32'hFF34_FF78};
        vecs[7]  = '{1'b1, 16'hBFF4, 32'hABCD_1234, 4'hF, 32'h0};
        vecs[8]  = '{1'b0, 16'hBFF4, 32'h0,        4'h0, 32'h0000_1234};
        vecs[9]  = '{1'b1, 16'h0004, 32'hFFFF_FFFF, 4'h1, 32'h0};
        vecs[10] = '{1'b0, 16'h0004, 32'h0,        4'h0, 32'h0000_0001};
        vecs[11] = '{1'b0, 16'h0008, 32'h0,        4'h0, 32'h0000_0000};
        vecs[12] = '{1'b1, 16'h0008, 32'h0000_0001, 4'hF, 32'h0};
        vecs[13] = '{1'b0, 16'h0000, 32'h0,        4'h0, 32'h0000_0000};
        vecs[14] = '{1'b0, 16'h1234, 32'h0,        4'h0, 32'h0000_0000};
        vecs[15] = '{1'b1, 16'h4010, 32'h0000_0000, 4'hF, 32'h0};
        vecs[16] = '{1'b0, 16'h4000, 32'h0,        4'h0, 32'hFFFF_FFFF};
        vecs[17] = '{1'b1, 16'hBFF0, 32'h0000_00FE, 4'h1, 32'h0};
        vecs[18] = '{1'b0, 16'hBFF0, 32'h0,        4'h0, 32'h0000_0000};
        vecs[19] = '{1'b1, 16'hBFF0, 32'hFFFF_FFFF, 4'hE, 32'h0};
        vecs[20] = '{1'b0, 16'hBFF0, 32'h0,        4'h0, 32'h0000_0000};
        vecs[21] = '{1'b1, 16'h4004, 32'hDEAD_BEEF, 4'h8, 32'h0};
        vecs[22] = '{1'b0, 16'h4004, 32'h0,        4'h0, 32'hDEFF_FFFF};
        vecs[23] = '{1'b0, 16'h400C, 32'h0,        4'h0, 32'hFFFF_FFFF};

        // Reset state
        do_reset();
        check("reset ready", 64'(ready), 64'd0);
        check("reset rdata", 64'(rdata), 64'd0);
        check("reset mtip",  64'(mtip),  64'd0);
        check("reset msip",  64'(msip),  64'd0);

        // Register access table
        for (int i = 0; i < NV; i++) begin
            xact(vecs[i].addr, vecs[i].wdata, vecs[i].is_wr ? vecs[i].wstrb : 4'h0,
                 $sformatf("vec%0d", i), r);
            if (!vecs[i].is_wr) begin
                check($sformatf("vec%0d rdata", i), 64'(r), 64'(vecs[i].exp));
            end
        end
        check("table msip", 64'(msip), 64'd2);
        check("table mtip", 64'(mtip), 64'd0);

        // Handshake latency and held-valid back-to-back pacing
        do_reset();
        idle(5);
        rd(16'hBFF8, r);
        check("first read mtime", 64'(r), 64'd5);
        address = 16'hBFF0;
        wstrb   = 4'h0;
        valid   = 1'b1;
        idle(1);
        check("held valid ready1", 64'(ready), 64'd1);
        idle(1);
        check("held valid gap", 64'(ready), 64'd0);
        idle(1);
        check("held valid ready2", 64'(ready), 64'd1);
        check("held valid rdata", 64'(rdata), 64'd1);
        valid = 1'b0;
        idle(1);
        check("held valid end", 64'(ready), 64'd0);

        // Prescaler, freeze and resume
        do_reset();
        wr(16'hBFF4, 32'd3, 4'hF);
        rd(16'hBFF8, m1);
        idle(6);
        rd(16'hBFF8, m2);
        rd(16'hBFF8, m3);
        check("presc m1", 64'(m1), 64'd1);
        check("presc m2", 64'(m2), 64'd3);
        check("presc m3", 64'(m3), 64'd3);
        wr(16'hBFF0, 32'd0, 4'h1);
        rd(16'hBFF8, m1);
        idle(10);
        rd(16'hBFF8, m2);
        check("frozen m1", 64'(m1), 64'd4);
        check("frozen m2", 64'(m2), 64'd4);
        wr(16'hBFF0, 32'd1, 4'h1);
        idle(6);
        rd(16'hBFF8, m3);
        check("resume", 64'(m3), 64'd6);

        // Timer interrupt on hart 1
        do_reset();
        wr(16'h4008, 32'h0000_0040, 4'hF);
        wr(16'h400C, 32'h0000_0000, 4'hF);
        check("mtip before", 64'(mtip), 64'd0);
        while ((mtip[1] !== 1'b1) && ((cyc - base) < 300)) begin
            idle(1);
        end
        check("mtip1 rise cycle", 64'(cyc - base), 64'd65);
        check("mtip0 stays low", 64'(mtip[0]), 64'd0);

        // mtime wrap and atomic low/high read
        do_reset();
        wr(16'hBFF0, 32'd0, 4'h1);
        wr(16'hBFFC, 32'hFFFF_FFFF, 4'hF);
        wr(16'hBFF8, 32'hFFFF_FFFF, 4'hF);
        rd(16'hBFF8, m1);
        rd(16'hBFFC, m2);
        check("max lo", 64'(m1), 64'hFFFF_FFFF);
        check("max hi", 64'(m2), 64'hFFFF_FFFF);
        wr(16'hBFF0, 32'd1, 4'h1);
        rd(16'hBFF8, m1);
        rd(16'hBFFC, m2);
        check("wrap lo", 64'(m1), 64'd0);
        check("wrap hi", 64'(m2), 64'd0);
        wr(16'hBFFC, 32'd5, 4'hF);
        wr(16'hBFF8, 32'hFFFF_FFFE, 4'hF);
        rd(16'hBFF8, m1);
        rd(16'hBFFC, m2);
        check("atomic lo", 64'(m1), 64'hFFFF_FFFF);
        check("atomic hi", 64'(m2), 64'd5);
        rd(16'hBFF8, m1);
        rd(16'hBFFC, m2);
        check("after carry lo", 64'(m1), 64'd3);
        check("after carry hi", 64'(m2), 64'd6);

        // Byte strobes on MSIP and out-of-range hart
        do_reset();
        wr(16'h0000, 32'd1, 4'h2);
        idle(2);
        check("msip wrong lane", 64'(msip), 64'd0);
        wr(16'h0000, 32'd1, 4'h1);
        check("msip set", 64'(msip), 64'd1);
        wr(16'h0008, 32'hFFFF_FFFF, 4'hF);
        idle(2);
        check("msip unmapped write", 64'(msip), 64'd1);
        rd(16'h0004, r);
        check("msip1 untouched", 64'(r), 64'd0);
        rd(16'h0000, r);
        check("msip0 readback", 64'(r), 64'd1);

        // Reset while in RESP after an MTIMECMP write
        do_reset();
        wr(16'h4000, 32'd0, 4'hF);
        wr(16'h4004, 32'd0, 4'hF);
        idle(2);
        check("mtip0 armed", 64'(mtip), 64'd1);
        address = 16'h4000;
        wdata   = 32'h0000_1234;
        wstrb   = 4'hF;
        valid   = 1'b1;
        idle(1);
        check("resp before reset", 64'(ready), 64'd1);
        reset = 1'b1;
        #1;
        check("async reset ready", 64'(ready), 64'd0);
        check("async reset mtip",  64'(mtip),  64'd0);
        check("async reset rdata", 64'(rdata), 64'd0);
        valid = 1'b0;
        wstrb = 4'h0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        base  = cyc;
        rd(16'h4000, r);
        check("cmp0 lo after reset", 64'(r), 64'hFFFF_FFFF);
        rd(16'h4004, r);
        check("cmp0 hi after reset", 64'(r), 64'hFFFF_FFFF);
        check("mtip after reset", 64'(mtip), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/iob_clint_rtc.md
IOB_CLINT_RTC -- requirements
Module: iob_clint_rtc

Interface
REQ-001 Parameter ADDR_W, default 16, address width; only address[15:0] is decoded.
REQ-002 Parameter DATA_W, default 32, bus data width; only 32 is supported.
REQ-003 Parameter N_CORES, default 1, hart count, range 1..8.
REQ-004 Parameter PRESC_W, default 16, prescaler width, range 1..32.
REQ-005 clk  input  1  single clock; all state is updated on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-007 valid  input  1  request strobe; the master holds it until ready.
REQ-008 address  input  ADDR_W  byte address; bits [1:0] are ignored.
REQ-009 wdata  input  DATA_W  write data.
REQ-010 wstrb  input  DATA_W/8  byte write enables; all-zero means read.
REQ-011 rdata  output  DATA_W  read data, valid only while ready=1.
REQ-012 ready  output  1  one-cycle completion pulse.
REQ-013 mtip  output  N_CORES  per-hart machine timer interrupt, registered.
REQ-014 msip  output  N_CORES  per-hart machine software interrupt, registered.

Function
REQ-015 Address map, word-aligned; k = hart index:
- MSIP[k] at 0x0000+4k: bit0 only.
- MTIMECMP[k] low at 0x4000+8k, high at 0x4004+8k.
- CTRL at 0xBFF0: bit0 = EN.
- PRESC at 0xBFF4: bits [PRESC_W-1:0].
- MTIME low at 0xBFF8, high at 0xBFFC.
REQ-016 Handshake FSM has two states, IDLE and RESP:
- IDLE with valid=1: latch the request, perform the access, go to RESP.
- RESP: ready=1 for exactly one cycle, rdata driven, return to IDLE.
- valid is ignored while in RESP.
REQ-017 Latency from valid in IDLE to ready is 1 cycle; back-to-back transactions take 2 cycles each.
REQ-018 Writes update only the byte lanes whose wstrb bit is set; unselected bytes are preserved.
REQ-019 Unimplemented register bits read as 0; writes to them are ignored.
REQ-020 An unmapped address, or a hart index >= N_CORES, reads 0, ignores writes, and still returns ready.
REQ-021 Prescaler behaviour when EN=1:
- a PRESC_W-bit counter pcnt counts 0..PRESC.
- a tick occurs in the cycle pcnt==PRESC; pcnt then returns to 0.
- PRESC=0 gives a tick every cycle.
REQ-022 When EN=0, pcnt and mtime hold their values and no tick occurs.
REQ-023 On each tick, mtime increments by 1 modulo 2^64; 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
REQ-024 Any write to PRESC clears pcnt to 0 in the same cycle.
REQ-025 A write to an MTIME half in the same cycle as a tick: the written bytes win, the increment is dropped that cycle, and there is no carry between halves.
REQ-026 A read of MTIME low returns mtime[31:0] and captures mtime[63:32] into a shadow register.
REQ-027 A read of MTIME high returns the shadow register, so a low-then-high read pair is atomic.
REQ-028 mtip[k] is registered as (mtime >= MTIMECMP[k]), unsigned 64-bit compare, evaluated every cycle, with 1-cycle lag after any change to mtime or MTIMECMP.
REQ-029 msip[k] equals MSIP[k].bit0, registered, with 1-cycle lag after the write.
REQ-030 All reads are side-effect free except the shadow capture in REQ-026.

Reset
REQ-031 On reset assertion, in any state, the following take effect asynchronously:
- FSM = IDLE, ready=0, rdata=0.
- mtime=0, shadow=0, pcnt=0.
- EN=1, PRESC=0.
- every MTIMECMP = all-ones.
- every MSIP=0, mtip=0, msip=0.
REQ-032 A transaction in progress when reset asserts is discarded; no write is committed, and no ready is issued for it.
REQ-033 After reset deassertion, mtime increments from the first rising clk edge.

Verification
REQ-034 Handshake: after reset, read MTIME low with valid held -> ready=1 exactly one cycle later with rdata equal to the cycle count; ready=0 on the following cycle.
REQ-035 Timer interrupt: N_CORES=2, write MTIMECMP[1] = 0x0000_0000_0000_0040 -> mtip[1] rises in the cycle after mtime reaches 0x40; mtip[0] stays 0.
REQ-036 Prescaler: write PRESC=3 -> mtime advances once every 4 cycles; write CTRL=0 -> mtime frozen; write CTRL=1 -> counting resumes.
REQ-037 Wrap and atomic read: write MTIME high=0xFFFF_FFFF and low=0xFFFF_FFFF -> mtime=0 one tick later; read low, then high -> the returned high word matches the value at the low read, even across a carry.
REQ-038 Byte strobes and msip: write MSIP[0] with wstrb=0b0010 -> msip[0] stays 0; write with wstrb=0b0001 and wdata=1 -> msip[0]=1 one cycle later; a write to address 0x0008 with N_CORES=1 -> ready=1, no state change.
REQ-039 Reset mid-operation: assert reset while the FSM is in RESP after a write to MTIMECMP[0] -> ready=0, MTIMECMP[0]=all-ones, mtip=0, all without waiting for a clk edge.
